mux_channel_scheduler: RTL

//  Round-robin scheduler that shares one 4:1 MUX -> 4-bit channel -> 1:4 DEMUX path among four requesters.

---
 rtl/mux_channel_scheduler_pkg.sv | 31 +++
 rtl/mux_channel_scheduler_if.sv | 21 ++
 rtl/mux_channel_scheduler_rr_pick4.sv | 27 ++
 rtl/mux_channel_scheduler.sv | 117 +++++++++++
 4 files changed

// File: rtl/mux_channel_scheduler_pkg.sv
// Shared types and encodings for the MUX/DEMUX channel scheduler.
package mux_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_e;

  localparam int NUM_SRC = 4;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  localparam logic [1:0] DEST_W = 2'b00;
  localparam logic [1:0] DEST_X = 2'b01;
  localparam logic [1:0] DEST_Y = 2'b10;
  localparam logic [1:0] DEST_Z = 2'b11;

  // Two-bit destination field belonging to source idx.
  function automatic logic [1:0] dest_of(input logic [7:0] dest, input logic [1:0] idx);
    return dest[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux_channel_scheduler_if.sv
// Request/steering bundle between the requesters, the scheduler and the MUX/DEMUX pair.
interface mux_channel_scheduler_if;
  logic [3:0] req;
  logic [7:0] dest;
  logic [3:0] grant;
  logic [1:0] mux_sel;
  logic       mux_en;
  logic [1:0] demux_sel;
  logic       demux_en;
  logic       busy;

  modport master (
    output req, dest,
    input  grant, mux_sel, mux_en, demux_sel, demux_en, busy
  );

  modport slave (
    input  req, dest,
    output grant, mux_sel, mux_en, demux_sel, demux_en, busy
  );
endinterface

// File: rtl/mux_channel_scheduler_rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping 3->0.
module rr_pick4
  import mux_sched_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] pos;

  // Scan from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    pos   = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pos = ptr + 2'(k);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mux_channel_scheduler.sv
// Round-robin owner of a shared 4:1 MUX -> channel -> 1:4 DEMUX path.
//
//   state | meaning
//   IDLE  | no owner, all outputs low, waiting for any request
//   GRANT | owner driving the path, one beat per cycle
//   GUARD | single dead cycle with enables low between owners
module mux_channel_scheduler
  import mux_sched_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  mux_channel_scheduler_if.slave  bus
);

  localparam int BW = $clog2(MAX_BURST + 1);

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [3:0]      grant_q, grant_d;
  logic [1:0]      mux_sel_q, mux_sel_d;
  logic [1:0]      demux_sel_q, demux_sel_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;

  logic            pick_valid;
  logic [1:0]      pick_idx;

  // ptr_q is already advanced on GUARD entry, so one picker serves IDLE and GUARD.
  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    grant_d     = grant_q;
    mux_sel_d   = mux_sel_q;
    demux_sel_d = demux_sel_q;
    en_d        = en_q;

    unique case (state_q)
      IDLE, GUARD: begin
        if (pick_valid) begin
          state_d     = GRANT;
          grant_d     = onehot4(pick_idx);
          mux_sel_d   = pick_idx;
          demux_sel_d = dest_of(bus.dest, pick_idx);
          en_d        = 1'b1;
          beat_cnt_d  = BW'(1);
        end else begin
          state_d     = IDLE;
          grant_d     = 4'b0000;
          mux_sel_d   = SEL_A;
          demux_sel_d = DEST_W;
          en_d        = 1'b0;
          beat_cnt_d  = '0;
        end
      end
      GRANT: begin
        // Selects hold through GUARD so the path never glitches between sources.
        if (!bus.req[mux_sel_q] || (beat_cnt_q == BW'(MAX_BURST))) begin
          state_d    = GUARD;
          grant_d    = 4'b0000;
          en_d       = 1'b0;
          ptr_d      = mux_sel_q + 2'd1;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      beat_cnt_q  <= '0;
      grant_q     <= 4'b0000;
      mux_sel_q   <= SEL_A;
      demux_sel_q <= DEST_W;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      grant_q     <= grant_d;
      mux_sel_q   <= mux_sel_d;
      demux_sel_q <= demux_sel_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.mux_sel   = mux_sel_q;
  assign bus.mux_en    = en_q;
  assign bus.demux_sel = demux_sel_q;
  assign bus.demux_en  = en_q;
  assign bus.busy      = busy_q;

endmodule
